cnn_div_sdiv_30s_8s: RTL and testbench

CNN_DIV_SDIV_30S_8S -- requirements
Module: cnn_div_sdiv_30s_8s

---
 rtl/cnn_div_sdiv_30s_8s.sv | 155 +++++++++++++++
 tb/tb_cnn_div_sdiv_30s_8s.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cnn_div_sdiv_30s_8s.sv
// Signed 30-bit by 8-bit sequential divider: radix-2 restoring core on the operand magnitudes,
// followed by a sign/saturation fix-up cycle and a one-cycle done pulse.
module cnn_div_sdiv_30s_8s #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned NUM_STAGE  = 32'd32,
  parameter int unsigned din0_WIDTH = 32'd30,
  parameter int unsigned din1_WIDTH = 32'd8,
  parameter int unsigned dout_WIDTH = 32'd24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int unsigned CNT_W     = 5;
  localparam int unsigned NUM_BITS  = 30;
  localparam int unsigned MAG_W     = 31;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign0_q, sign0_d, sign1_q, sign1_d;
  logic [MAG_W-1:0]   nmag_q, nmag_d;
  logic [7:0]         dmag_q, dmag_d;
  logic [7:0]         prem_q, prem_d;
  logic [23:0]        dout_q, dout_d;
  logic [7:0]         rem_q, rem_d;
  logic               ovf_q, ovf_d, dbz_q, dbz_d;
  logic               done_q, done_d, ready_q, ready_d;

  logic [MAG_W-1:0]   din0_ext;
  logic [8:0]         din1_ext;
  logic [8:0]         trial;
  logic               trial_ge;
  logic [7:0]         trial_diff;
  logic               unused_params;

  assign unused_params = ^{32'(ID), 32'(NUM_STAGE)};

  assign din0_ext   = {din0[29], din0};
  assign din1_ext   = {din1[7], din1};
  // Partial remainder stays below the divisor (<=128), so 9 bits hold the shifted trial value.
  assign trial      = {prem_q, nmag_q[29]};
  assign trial_ge   = trial >= {1'b0, dmag_q};
  assign trial_diff = trial[7:0] - dmag_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign0_d = sign0_q;
    sign1_d = sign1_q;
    nmag_d  = nmag_q;
    dmag_d  = dmag_q;
    prem_d  = prem_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign0_d = din0[29];
          sign1_d = din1[7];
          nmag_d  = din0[29] ? MAG_W'(31'd0 - din0_ext) : din0_ext;
          dmag_d  = 8'(din1[7] ? 9'd0 - din1_ext : din1_ext);
          prem_d  = 8'd0;
          cnt_d   = '0;
          state_d = (din1 == 8'd0) ? FIX : CALC;
        end
      end
      CALC: begin
        // Quotient bits shift in at the bottom while dividend bits leave from bit 29.
        prem_d = trial_ge ? trial_diff : trial[7:0];
        nmag_d = {1'b0, nmag_q[28:0], trial_ge};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_BITS - 1)) state_d = FIX;
      end
      FIX: begin
        if (dmag_q == 8'd0) begin
          dbz_d  = 1'b1;
          ovf_d  = 1'b1;
          rem_d  = 8'd0;
          dout_d = sign0_q ? 24'h800000 : 24'h7FFFFF;
        end else begin
          dbz_d = 1'b0;
          rem_d = sign0_q ? 8'(8'd0 - prem_q) : prem_q;
          if (sign0_q ^ sign1_q) begin
            ovf_d  = nmag_q > 31'd8388608;
            dout_d = ovf_d ? 24'h800000 : 24'(31'd0 - nmag_q);
          end else begin
            ovf_d  = nmag_q > 31'd8388607;
            dout_d = ovf_d ? 24'h7FFFFF : 24'(nmag_q);
          end
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
      nmag_q  <= '0;
      dmag_q  <= '0;
      prem_q  <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign0_q <= sign0_d;
      sign1_q <= sign1_d;
      nmag_q  <= nmag_d;
      dmag_q  <= dmag_d;
      prem_q  <= prem_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign dout  = dout_q;
  assign rem   = rem_q;
  assign ovf   = ovf_q;
  assign dbz   = dbz_q;

endmodule

// File: tb/tb_cnn_div_sdiv_30s_8s.sv
// Self-checking bench for cnn_div_sdiv_30s_8s: directed vector table, random vectors against a
// behavioural model, and hand sequences for clock-enable freeze and mid-division reset.
module tb_cnn_div_sdiv_30s_8s;

  logic        clk = 1'b0;
  logic        reset, ce, start;
  logic [29:0] din0;
  logic [7:0]  din1;
  logic        ready, done, ovf, dbz;
  logic [23:0] dout;
  logic [7:0]  rem;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int ovf;
    int dbz;
    int lat;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  cnn_div_sdiv_30s_8s dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .din0(din0), .din1(din1),
    .ready(ready), .done(done), .dout(dout), .rem(rem), .ovf(ovf), .dbz(dbz)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t model(input int a, input int b);
    vec_t v;
    int q;
    v.a = a; v.b = b;
    if (b == 0) begin
      v.q = (a < 0) ? -8388608 : 8388607;
      v.r = 0; v.ovf = 1; v.dbz = 1; v.lat = 2;
    end else begin
      q = a / b;
      v.r = a % b; v.dbz = 0; v.lat = 32; v.ovf = 0; v.q = q;
      if (q > 8388607) begin v.q = 8388607; v.ovf = 1; end
      if (q < -8388608) begin v.q = -8388608; v.ovf = 1; end
    end
    return v;
  endfunction

  task automatic run_op(input vec_t e, input int freeze, input bit hold_done, input string tag);
    int   lat;
    vec_t x;
    for (int i = 0; i < 100 && !ready; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_ready_idle"}, int'(ready), 1);
    din0 = 30'(e.a); din1 = 8'(e.b); start = 1'b1; ce = 1'b1;
    @(posedge clk); #1;
    sb.push_back(e);
    start = 1'b0; din0 = 30'($urandom); din1 = 8'($urandom);
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 3) begin
        chk({tag, "_ready_busy"}, int'(ready), 0);
        start = 1'b1;
      end
      if (lat == 4) start = 1'b0;
      ce = (freeze > 0 && lat >= 6 && lat < 6 + freeze) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    ce = 1'b1; start = 1'b0;
    x = sb.pop_front();
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected latency %0d", tag, lat, x.lat);
      return;
    end
    chk({tag, "_latency"}, lat, x.lat + freeze);
    chk({tag, "_dout"}, int'($signed(dout)), x.q);
    chk({tag, "_rem"}, int'($signed(rem)), x.r);
    chk({tag, "_ovf"}, int'(ovf), x.ovf);
    chk({tag, "_dbz"}, int'(dbz), x.dbz);
    if (hold_done) begin
      ce = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk({tag, "_done_frozen"}, int'(done), 1);
      ce = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_ready_after"}, int'(ready), 1);
  endtask

  initial begin
    vec_t v;
    int   nd;
    logic [29:0] ra;
    logic [7:0]  rb;

    tbl[0]  = '{-1000,       7,    -142,     -6, 0, 0, 32};
    tbl[1]  = '{-617280,    -5,    123456,    0, 0, 0, 32};
    tbl[2]  = '{536870911,   1,    8388607,   0, 1, 0, 32};
    tbl[3]  = '{-536870912, -1,    8388607,   0, 1, 0, 32};
    tbl[4]  = '{-5,          0,    -8388608,  0, 1, 1, 2};
    tbl[5]  = '{100,         0,    8388607,   0, 1, 1, 2};
    tbl[6]  = '{-536870912, 64,    -8388608,  0, 0, 0, 32};
    tbl[7]  = '{536870911,  64,    8388607,  63, 0, 0, 32};
    tbl[8]  = '{536870911, -64,    -8388607, 63, 0, 0, 32};
    tbl[9]  = '{-536870912,-64,    8388607,   0, 1, 0, 32};
    tbl[10] = '{7,        -128,    0,         7, 0, 0, 32};
    tbl[11] = '{-129,     -128,    1,        -1, 0, 0, 32};
    tbl[12] = '{0,           5,    0,         0, 0, 0, 32};

    reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_dbz", int'(dbz), 0);

    for (int i = 0; i < 13; i++) run_op(tbl[i], 0, 1'b0, $sformatf("vec%0d", i));

    // Results hold while idle with garbage on the inputs.
    repeat (5) begin
      din0 = 30'($urandom); din1 = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("hold_dout", int'($signed(dout)), 0);
    chk("hold_ready", int'(ready), 1);

    run_op(tbl[0], 10, 1'b0, "freeze_calc");
    run_op(tbl[4], 0, 1'b1, "freeze_done");

    // Reset in the middle of CALC, with ce low to show reset wins over ce.
    din0 = 30'(12345); din1 = 8'(11); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    reset = 1'b1; ce = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; ce = 1'b1;
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_done", int'(done), 0);
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_rem", int'(rem), 0);
    chk("midrst_ovf", int'(ovf), 0);
    chk("midrst_dbz", int'(dbz), 0);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    run_op(model(12345, 11), 0, 1'b0, "after_rst");

    for (int i = 0; i < 20; i++) begin
      ra = 30'($urandom);
      rb = (i % 7 == 3) ? 8'd0 : 8'($urandom);
      v  = model(int'($signed(ra)), int'($signed(rb)));
      run_op(v, 0, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
